pwm_multi: RTL

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_prescaler.sv | 22 ++
 rtl/pwm_multi.sv | 71 +++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults for the multi-channel PWM block
// CH_DEF channels, W_DEF counter/period/duty width, PW_DEF prescaler width,
// DUTY_W width of one channel's slice of the packed duty bus
package pwm_pkg;
    localparam int CH_DEF = 2;
    localparam int W_DEF  = 8;
    localparam int PW_DEF = 16;
    localparam int DUTY_W = W_DEF;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk_in into one-clock ticks every presc+1 clocks
// clk_in/reset: clock, sync active-high reset; en: run enable, low holds count at 0
// presc: divide value, takes effect immediately; tick: one-clock count strobe
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          en,
    input  logic [PW-1:0] presc,
    output logic          tick
);
    logic [PW-1:0] r_cnt;
    // >= lets a count already past a lowered presc restart without a tick
    always_ff @(posedge clk_in) begin
        if (reset || !en) r_cnt <= '0;
        else              r_cnt <= (r_cnt >= presc) ? '0 : r_cnt + PW'(1);
    end
    assign tick = en && (r_cnt == presc);
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM with shared prescaled period counter and frame-aligned duty updates
// clk_in/reset: clock, sync active-high reset; en: run enable
// presc: prescale value; period: terminal count; duty: packed per-channel duty, W bits each
// load: strobe capturing period/duty into shadows; pwm: registered outputs; frame_end: wrap pulse
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int W  = DUTY_W,
    parameter int PW = PW_DEF
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          en,
    input  logic [PW-1:0] presc,
    input  logic [W-1:0]  period,
    input  logic [CH*W-1:0] duty,
    input  logic          load,
    output logic [CH-1:0] pwm,
    output logic          frame_end
);
    logic         w_tick, w_wrap, w_act_upd;
    logic [W-1:0] r_cnt, r_period_sh, r_period_act;
    logic         r_frame_end;

    pwm_prescaler #(.PW(PW)) u_presc (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (en),
        .presc  (presc),
        .tick   (w_tick)
    );

    assign w_wrap = w_tick && (r_cnt == r_period_act);
    // Active values track the shadows while disabled so enabling starts with them;
    // otherwise they only move at the wrap, with a coincident load bypassing the shadow.
    assign w_act_upd = !en || w_wrap;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt        <= '0;
            r_period_sh  <= '0;
            r_period_act <= '0;
            r_frame_end  <= 1'b0;
        end else begin
            r_cnt       <= (!en || w_wrap) ? '0 : w_tick ? r_cnt + W'(1) : r_cnt;
            r_frame_end <= w_wrap;
            if (load)      r_period_sh  <= period;
            if (w_act_upd) r_period_act <= load ? period : r_period_sh;
        end
    end

    assign frame_end = r_frame_end;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] r_duty_sh, r_duty_act;
        logic         r_pwm;
        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_duty_sh  <= '0;
                r_duty_act <= '0;
                r_pwm      <= 1'b0;
            end else begin
                if (load)      r_duty_sh  <= duty[c*W +: W];
                if (w_act_upd) r_duty_act <= load ? duty[c*W +: W] : r_duty_sh;
                r_pwm <= en && (r_cnt < r_duty_act);
            end
        end
        assign pwm[c] = r_pwm;
    end
endmodule
